turnike_giris: RTL and testbench

TURNIKE_GIRIS -- requirements
Module: turnike_giris

---
 rtl/turnike_giris.sv | 158 +++++++++++++++
 tb/tb_turnike_giris.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/turnike_giris.sv
// rtl/turnike_giris.sv - debounced two-button turnstile gate controller with pass counters
// Entry/exit buttons are synchronized and debounced; each accepted press opens the gate for a fixed window.
module turnike_giris #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int OPEN_CYCLES     = 100_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn1,
    input  logic             btn2,
    output logic             pass_in,
    output logic             pass_out,
    output logic             gate_busy,
    output logic [1:0]       dir,
    output logic [CNT_W-1:0] in_count,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] occupancy
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]    T_LOAD  = TW'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OPEN_IN  = 2'd1,
        OPEN_OUT = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Index 0 is the entry button, index 1 the exit button.
    logic [1:0]    raw;
    logic [1:0]    meta_q;
    logic [1:0]    sync_q;
    logic [1:0]    db_q;
    logic [1:0]    db_prev_q;
    logic [1:0]    press;
    logic [DW-1:0] stab_q [2];

    assign raw   = {btn2, btn1};
    assign press = db_prev_q & ~db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q    <= 2'b11;
            sync_q    <= 2'b11;
            db_q      <= 2'b11;
            db_prev_q <= 2'b11;
            stab_q[0] <= '0;
            stab_q[1] <= '0;
        end else begin
            meta_q    <= raw;
            sync_q    <= meta_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != db_q[i]) begin
                    if (stab_q[i] == DB_LAST) begin
                        db_q[i]   <= sync_q[i];
                        stab_q[i] <= '0;
                    end else begin
                        stab_q[i] <= stab_q[i] + DW'(1);
                    end
                end else begin
                    stab_q[i] <= '0;
                end
            end
        end
    end

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pass_in_q, pass_in_d;
    logic             pass_out_q, pass_out_d;
    logic             busy_q, busy_d;
    logic [1:0]       dir_q, dir_d;
    logic [CNT_W-1:0] in_q, in_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] occ_q, occ_d;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pass_in_d  = 1'b0;
        pass_out_d = 1'b0;
        in_d       = in_q;
        out_d      = out_q;
        occ_d      = occ_q;
        case (state_q)
            IDLE: begin
                // Entry wins a same-cycle tie; the exit event is simply dropped.
                if (press[0]) begin
                    state_d   = OPEN_IN;
                    timer_d   = T_LOAD;
                    pass_in_d = 1'b1;
                    if (in_q != CNT_MAX)  in_d  = in_q + CNT_W'(1);
                    if (occ_q != CNT_MAX) occ_d = occ_q + CNT_W'(1);
                end else if (press[1]) begin
                    state_d    = OPEN_OUT;
                    timer_d    = T_LOAD;
                    pass_out_d = 1'b1;
                    if (out_q != CNT_MAX) out_d = out_q + CNT_W'(1);
                    if (occ_q != '0)      occ_d = occ_q - CNT_W'(1);
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (timer_q == '0) state_d = WAIT_REL;
                else               timer_d = timer_q - TW'(1);
            end
            WAIT_REL: begin
                if (&db_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        case (state_d)
            OPEN_IN:  dir_d = 2'b01;
            OPEN_OUT: dir_d = 2'b10;
            default:  dir_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pass_in_q  <= 1'b0;
            pass_out_q <= 1'b0;
            busy_q     <= 1'b0;
            dir_q      <= 2'b00;
            in_q       <= '0;
            out_q      <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pass_in_q  <= pass_in_d;
            pass_out_q <= pass_out_d;
            busy_q     <= busy_d;
            dir_q      <= dir_d;
            in_q       <= in_d;
            out_q      <= out_d;
            occ_q      <= occ_d;
        end
    end

    assign pass_in   = pass_in_q;
    assign pass_out  = pass_out_q;
    assign gate_busy = busy_q;
    assign dir       = dir_q;
    assign in_count  = in_q;
    assign out_count = out_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_turnike_giris.sv
// tb/tb_turnike_giris.sv - scenario table, corner sequences and random stimulus against a reference model
// Small parameters keep debounce, window and counter saturation reachable in a short run.
module tb_turnike_giris;

    localparam int DB    = 4;
    localparam int OC    = 10;
    localparam int CW    = 3;
    localparam int MAXV  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn1 = 1'b1;
    logic          btn2 = 1'b1;
    logic          pass_in, pass_out, gate_busy;
    logic [1:0]    dir;
    logic [CW-1:0] in_count, out_count, occupancy;

    turnike_giris #(.DEBOUNCE_CYCLES(DB), .OPEN_CYCLES(OC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .btn1(btn1), .btn2(btn2),
        .pass_in(pass_in), .pass_out(pass_out), .gate_busy(gate_busy), .dir(dir),
        .in_count(in_count), .out_count(out_count), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 entry window, 2 exit window, 3 waiting for release.
    int m_syn0 [2], m_syn1 [2], m_db [2], m_run [2], m_fell [2];
    int m_phase, m_left, m_pin, m_pout, m_inc, m_outc, m_occ;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_syn0[i] = 1; m_syn1[i] = 1; m_db[i] = 1; m_run[i] = 0; m_fell[i] = 0;
        end
        m_phase = 0; m_left = 0; m_pin = 0; m_pout = 0;
        m_inc = 0; m_outc = 0; m_occ = 0;
    endfunction

    function automatic void model_step(int r1, int r2);
        int raw [2];
        raw[0] = r1; raw[1] = r2;
        m_pin = 0; m_pout = 0;
        if (m_phase == 0) begin
            if (m_fell[0] != 0) begin
                m_phase = 1; m_left = OC; m_pin = 1;
                m_inc = (m_inc < MAXV) ? m_inc + 1 : MAXV;
                m_occ = (m_occ < MAXV) ? m_occ + 1 : MAXV;
            end else if (m_fell[1] != 0) begin
                m_phase = 2; m_left = OC; m_pout = 1;
                m_outc = (m_outc < MAXV) ? m_outc + 1 : MAXV;
                m_occ  = (m_occ > 0) ? m_occ - 1 : 0;
            end
        end else if (m_phase == 1 || m_phase == 2) begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 3;
        end else if (m_db[0] == 1 && m_db[1] == 1) begin
            m_phase = 0;
        end
        for (int i = 0; i < 2; i++) begin
            m_fell[i] = 0;
            if (m_syn1[i] != m_db[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_db[i] = m_syn1[i];
                    m_run[i] = 0;
                    if (m_db[i] == 0) m_fell[i] = 1;
                end
            end else begin
                m_run[i] = 0;
            end
            m_syn1[i] = m_syn0[i];
            m_syn0[i] = raw[i];
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pass_in",   int'(pass_in),   m_pin);
        chk("pass_out",  int'(pass_out),  m_pout);
        chk("gate_busy", int'(gate_busy), (m_phase != 0) ? 1 : 0);
        chk("dir",       int'(dir),       (m_phase == 1) ? 1 : (m_phase == 2) ? 2 : 0);
        chk("in_count",  int'(in_count),  m_inc);
        chk("out_count", int'(out_count), m_outc);
        chk("occupancy", int'(occupancy), m_occ);
    endtask

    int n_in, n_out, n_dir1, n_dir2;

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(int'(btn1), int'(btn2));
        #1;
        check_all();
        if (pass_in)     n_in++;
        if (pass_out)    n_out++;
        if (dir == 2'b01) n_dir1++;
        if (dir == 2'b10) n_dir2++;
    endtask

    task automatic clear_counts();
        n_in = 0; n_out = 0; n_dir1 = 0; n_dir2 = 0;
    endtask

    typedef struct {
        int    b1_lo;
        int    b2_lo;
        int    b2_at;
        bit    b2_tog;
        int    exp_in;
        int    exp_out;
        string name;
    } row_t;

    row_t rows [6];

    initial begin
        rows[0] = '{0,  8,  0, 1'b0, 0, 1, "exit_at_zero"};
        rows[1] = '{20, 0,  0, 1'b0, 1, 0, "entry_hold20"};
        rows[2] = '{0,  0,  0, 1'b1, 0, 0, "btn2_bounce"};
        rows[3] = '{12, 12, 0, 1'b0, 1, 0, "simultaneous"};
        rows[4] = '{3,  0,  0, 1'b0, 0, 0, "short_glitch"};
        rows[5] = '{30, 6,  8, 1'b0, 1, 0, "exit_during_open"};

        model_reset();
        #12;
        check_all();
        chk("reset_busy", int'(gate_busy), 0);
        chk("reset_dir",  int'(dir), 0);
        tick();
        rst_n = 1'b1;

        foreach (rows[r]) begin
            clear_counts();
            for (int c = 0; c < 80; c++) begin
                btn1 = (c < rows[r].b1_lo) ? 1'b0 : 1'b1;
                if (rows[r].b2_tog)
                    btn2 = (c < 16) ? 1'((c / 2) % 2) : 1'b1;
                else
                    btn2 = (c >= rows[r].b2_at && c < rows[r].b2_at + rows[r].b2_lo) ? 1'b0 : 1'b1;
                tick();
            end
            chk({rows[r].name, "_pulses_in"},  n_in,  rows[r].exp_in);
            chk({rows[r].name, "_pulses_out"}, n_out, rows[r].exp_out);
            chk({rows[r].name, "_dir_in_cycles"},  n_dir1, OC * rows[r].exp_in);
            chk({rows[r].name, "_dir_out_cycles"}, n_dir2, OC * rows[r].exp_out);
            if (r == 0) chk("exit_at_zero_occupancy", int'(occupancy), 0);
            chk({rows[r].name, "_idle_after"}, int'(gate_busy), 0);
        end
        chk("table_in_count",  int'(in_count),  3);
        chk("table_out_count", int'(out_count), 1);
        chk("table_occupancy", int'(occupancy), 3);

        // Re-press during the window and hold past expiry: one pulse, gate held until release.
        clear_counts();
        btn1 = 1'b0; repeat (6) tick();
        btn1 = 1'b1; repeat (4) tick();
        btn1 = 1'b0; repeat (40) tick();
        chk("hold_busy_before_release", int'(gate_busy), 1);
        chk("hold_dir_waiting", int'(dir), 0);
        btn1 = 1'b1; repeat (40) tick();
        chk("hold_pulses", n_in, 1);
        chk("hold_released", int'(gate_busy), 0);

        // Reset five cycles into an entry window, with the button still held through reset.
        btn1 = 1'b0;
        begin
            int budget;
            budget = 0;
            while (m_phase != 1 && budget < 40) begin
                tick();
                budget++;
            end
            chk("reach_open_in", m_phase, 1);
        end
        repeat (5) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_pass_in",  int'(pass_in), 0);
        chk("midrst_busy",     int'(gate_busy), 0);
        chk("midrst_dir",      int'(dir), 0);
        chk("midrst_in_count", int'(in_count), 0);
        chk("midrst_occ",      int'(occupancy), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_counts();
        repeat (40) tick();
        btn1 = 1'b1;
        repeat (40) tick();
        chk("post_reset_pulses", n_in, 1);
        chk("post_reset_in_count", int'(in_count), 1);

        // Saturation of entry count and occupancy.
        for (int k = 0; k < 9; k++) begin
            btn1 = 1'b0; repeat (8) tick();
            btn1 = 1'b1; repeat (30) tick();
        end
        chk("sat_in_count",  int'(in_count), MAXV);
        chk("sat_occupancy", int'(occupancy), MAXV);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) btn1 = ~btn1;
            if ($urandom_range(0, 9) == 0) btn2 = ~btn2;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
